// File: rtl/dm_sync_be.sv
// dm_sync_be: word-organised single-port data memory with byte-enable writes,
// registered reads, post-reset zero sweep, address checking and write trace.
`default_nettype none

module dm_sync_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Req,
    input  logic                We,
    input  logic [DATA_W/8-1:0] ByteEnable,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   WD,
    input  logic [31:0]         WPC,
    output logic [DATA_W-1:0]   RD,
    output logic                RdValid,
    output logic                Ready,
    output logic                AddrErr,
    output logic [15:0]         WrCount,
    output logic [31:0]         LastWPC
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic               misaligned;
    logic               out_of_range;
    logic               legal;
    logic               accept;
    logic [DATA_W-1:0]  mem [DEPTH];

    generate
        if (OFF > 0) begin : g_align
            assign misaligned = |Addr[OFF-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end

        // Any set bit above the index field means Addr >= DEPTH*BYTES.
        if (ADDR_W > IDX_W + OFF) begin : g_range
            assign out_of_range = |Addr[ADDR_W-1:IDX_W+OFF];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign idx    = Addr[IDX_W+OFF-1:OFF];
    assign legal  = !misaligned && !out_of_range;
    assign accept = (state == IDLE) && Req;
    assign Ready  = (state == IDLE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (ptr == IDX_W'(DEPTH - 1)) state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + IDX_W'(1);
        end
    end

    // Storage has no reset; the sweep zeroes it one word per cycle instead.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (accept && We && legal) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (ByteEnable[i]) mem[idx][8*i +: 8] <= WD[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            RD      <= '0;
            RdValid <= 1'b0;
            AddrErr <= 1'b0;
            WrCount <= '0;
            LastWPC <= '0;
        end else begin
            RdValid <= 1'b0;
            AddrErr <= 1'b0;
            if (accept) begin
                if (!legal) begin
                    AddrErr <= 1'b1;
                    if (!We) begin
                        RdValid <= 1'b1;
                        RD      <= '0;
                    end
                end else if (!We) begin
                    RdValid <= 1'b1;
                    RD      <= mem[idx];
                end else if (|ByteEnable) begin
                    WrCount <= (WrCount == 16'hFFFF) ? WrCount : WrCount + 16'd1;
                    LastWPC <= WPC;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_sync_be.sv
// tb_dm_sync_be: directed plan checks plus randomized traffic compared each
// cycle against a behavioural model of the memory.
`default_nettype none

module tb_dm_sync_be;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Req = 1'b0;
    logic              We = 1'b0;
    logic [BYTES-1:0]  ByteEnable = '0;
    logic [ADDR_W-1:0] Addr = '0;
    logic [DATA_W-1:0] WD = '0;
    logic [31:0]       WPC = '0;
    logic [DATA_W-1:0] RD;
    logic              RdValid;
    logic              Ready;
    logic              AddrErr;
    logic [15:0]       WrCount;
    logic [31:0]       LastWPC;

    int n_checks = 0;
    int n_errors = 0;

    dm_sync_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clock(clk), .Reset(Reset), .Req(Req), .We(We), .ByteEnable(ByteEnable),
        .Addr(Addr), .WD(WD), .WPC(WPC), .RD(RD), .RdValid(RdValid),
        .Ready(Ready), .AddrErr(AddrErr), .WrCount(WrCount), .LastWPC(LastWPC)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the sweep is just a countdown of DEPTH edges after
    // which the whole array reads as zero.
    bit              m_valid = 0;
    bit              m_clear;
    int              m_cnt;
    logic [31:0]     m_mem [DEPTH];
    logic [31:0]     m_rd;
    logic            m_rdv, m_err;
    logic [15:0]     m_wc;
    logic [31:0]     m_lpc;

    always @(posedge clk) begin
        longint a;
        bit     ok;
        if (!Reset) begin
            m_valid = 1; m_clear = 1; m_cnt = 0;
            m_rd = 0; m_rdv = 0; m_err = 0; m_wc = 0; m_lpc = 0;
        end else if (m_valid) begin
            m_rdv = 0; m_err = 0;
            if (m_clear) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_clear = 0;
                    foreach (m_mem[k]) m_mem[k] = 0;
                end
            end else if (Req) begin
                a  = longint'(Addr);
                ok = (a % BYTES == 0) && (a < DEPTH * BYTES);
                if (!ok) begin
                    m_err = 1;
                    if (!We) begin m_rdv = 1; m_rd = 0; end
                end else if (!We) begin
                    m_rdv = 1; m_rd = m_mem[a / BYTES];
                end else if (ByteEnable != 0) begin
                    for (int b = 0; b < BYTES; b++)
                        if (ByteEnable[b]) m_mem[a / BYTES][8*b +: 8] = WD[8*b +: 8];
                    if (m_wc != 16'hFFFF) m_wc = m_wc + 1;
                    m_lpc = WPC;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ready",   64'(Ready),   64'(!m_clear));
            check("model_rdvalid", 64'(RdValid), 64'(m_rdv));
            check("model_addrerr", 64'(AddrErr), 64'(m_err));
            check("model_rd",      64'(RD),      64'(m_rd));
            check("model_wrcount", 64'(WrCount), 64'(m_wc));
            check("model_lastwpc", 64'(LastWPC), 64'(m_lpc));
        end
    end

    task automatic issue(input logic rq, input logic we, input logic [3:0] be,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] pc);
        @(negedge clk);
        Req = rq; We = we; ByteEnable = be; Addr = ad; WD = wd; WPC = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        Reset = 1'b1;
        Req = 1'b1; We = 1'b0; Addr = 32'd8;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (Ready) break;
        end
        check(name, 64'(n), 64'(DEPTH));
    endtask

    initial begin
        logic [31:0] ad;
        Reset = 1'b0;
        repeat (3) step();
        check("rst_ready",   64'(Ready),   64'd0);
        check("rst_rd",      64'(RD),      64'd0);
        check("rst_rdvalid", 64'(RdValid), 64'd0);
        check("rst_wrcount", 64'(WrCount), 64'd0);
        check("rst_lastwpc", 64'(LastWPC), 64'd0);

        wait_ready("sweep_len");

        issue(1, 0, 4'h0, 32'd3000, 0, 0); step();
        check("rd3000_rd", 64'(RD), 64'd0);
        check("rd3000_v",  64'(RdValid), 64'd1);

        issue(1, 1, 4'b1100, 32'd2000, 32'h11223344, 32'h3040); step();
        check("wr_rdvalid", 64'(RdValid), 64'd0);
        check("wr_count",   64'(WrCount), 64'd1);
        check("wr_lastwpc", 64'(LastWPC), 64'h3040);
        issue(1, 0, 4'h0, 32'd2000, 0, 0); step();
        check("merge_rd", 64'(RD), 64'h11220000);

        issue(1, 1, 4'hF, 32'd2002, 32'hdeadbeef, 32'h5000); step();
        check("mis_err",   64'(AddrErr), 64'd1);
        check("mis_count", 64'(WrCount), 64'd1);
        issue(1, 0, 4'h0, 32'd4096, 0, 0); step();
        check("oor_err", 64'(AddrErr), 64'd1);
        check("oor_v",   64'(RdValid), 64'd1);
        check("oor_rd",  64'(RD),      64'd0);

        issue(1, 1, 4'h0, 32'd2000, 32'haabbccdd, 32'h6000); step();
        check("be0_err",   64'(AddrErr), 64'd0);
        check("be0_count", 64'(WrCount), 64'd1);
        issue(1, 0, 4'h0, 32'd2000, 0, 0); step();
        check("be0_rd", 64'(RD), 64'h11220000);

        for (int i = 0; i < 3; i++) issue(1, 1, 4'hF, 32'(4 * i), 32'hA0 + 32'(i), 32'h100);
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 4'h0, 32'(4 * i), 0, 0); step();
            check("b2b_v",  64'(RdValid), 64'd1);
            check("b2b_rd", 64'(RD), 64'hA0 + 64'(i));
        end
        issue(0, 0, 4'h0, 0, 0, 0); step();
        check("pulse_clr", 64'(RdValid), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            ad = 32'($urandom_range(0, 15)) * 4;
            case ($urandom_range(0, 15))
                0, 1: ad = ad + 32'($urandom_range(1, 3));
                2:    ad = 32'd4096 + 32'($urandom_range(0, 64));
                3:    ad = $urandom;
                default: ;
            endcase
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom), ad, $urandom, $urandom);
        end
        issue(0, 0, 4'h0, 0, 0, 0);

        // Abort the sweep at its 500th edge and require a full restart.
        Reset = 1'b0; step();
        @(negedge clk);
        Reset = 1'b1;
        repeat (499) @(negedge clk);
        Reset = 1'b0;
        step();
        check("abort_ready", 64'(Ready), 64'd0);
        wait_ready("resweep_len");
        issue(1, 0, 4'h0, 32'd2000, 0, 0); step();
        check("resweep_rd", 64'(RD),      64'd0);
        check("resweep_wc", 64'(WrCount), 64'd0);
        issue(0, 0, 4'h0, 0, 0, 0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_sync_be.md
Name: dm_sync_be

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM with configurable data width and depth.
- Byte-enable writes, registered 1-cycle-latency reads, and hardware zero-clear after reset via a sweep FSM.
- Alignment and range checking, plus write-trace registers (write count, last writing PC) for FPGA debug.
- Sits in the MEM stage; the pipeline must sample Ready before issuing requests.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8, at least 8. BYTES = DATA_W/8; OFF = log2(BYTES), 0 when BYTES=1.
- DEPTH, 1024, number of words; power of two, at least 2. IDX_W = log2(DEPTH).
- ADDR_W, 32, byte-address width; must be at least IDX_W+OFF.

Ports:
- Clock  in  1  rising-edge clock, the only clock.
- Reset  in  1  synchronous, active-low reset.
- Req  in  1  access request; taken only when Ready=1.
- We  in  1  1 = write, 0 = read; qualified by Req.
- ByteEnable  in  BYTES  per-byte write strobe; bit i covers WD[8i+7:8i].
- Addr  in  ADDR_W  byte address.
- WD  in  DATA_W  write data.
- WPC  in  32  PC of the issuing instruction, for trace only.
- RD  out  DATA_W  registered read data; holds its value between reads.
- RdValid  out  1  one-cycle pulse; RD is valid that cycle.
- Ready  out  1  1 = IDLE, requests accepted.
- AddrErr  out  1  one-cycle pulse on a rejected access.
- WrCount  out  16  count of committed writes; saturates at 16'hFFFF.
- LastWPC  out  32  WPC of the most recent committed write.

Behaviour:
- Clock and reset:
  - Reset is sampled only at the rising edge of Clock.
  - Reset=0 at an edge sets: state=CLEAR, ptr=0, RD=0, RdValid=0, AddrErr=0, Ready=0, WrCount=0, LastWPC=0.
  - Memory contents are not cleared in that same cycle.
- State CLEAR:
  - Each edge with Reset=1 writes zero to mem[ptr] and increments ptr.
  - The edge that writes mem[DEPTH-1] moves state to IDLE.
  - Ready rises exactly DEPTH edges after the first edge with Reset=1.
  - Req is ignored in CLEAR: no RdValid, no AddrErr.
- State IDLE:
  - Ready=1. A request is accepted on an edge where Req=1.
  - idx = Addr[IDX_W+OFF-1:OFF].
  - An access is illegal when Addr[OFF-1:0] is not 0, or Addr >= DEPTH*BYTES.
- Illegal access:
  - AddrErr=1 for the following cycle.
  - No memory change, no trace update.
  - For a read, RdValid=1 with RD=0.
- Legal read:
  - RD=mem[idx] and RdValid=1 in the cycle after acceptance: 1-cycle latency.
  - Back-to-back reads every cycle are supported.
- Legal write:
  - At the acceptance edge, byte i of mem[idx] takes WD byte i where ByteEnable[i]=1; other bytes are kept.
  - If ByteEnable is nonzero: WrCount increments (saturating) and LastWPC=WPC.
  - ByteEnable=0 is a no-op write: no memory change, no trace update, no AddrErr, unless the access is illegal.
  - Writes never pulse RdValid and never change RD.
- Write then read of the same word on the next edge returns the merged data; no hazard is possible with a single port.
- RdValid and AddrErr are single-cycle pulses, cleared on any edge with no qualifying event.
- Reset=0 during CLEAR or IDLE aborts everything; the next release restarts the full sweep from ptr=0.
- Pending output pulses are cleared by reset.
- No X may propagate to any output after reset.

Test Plan (defaults DATA_W=32, DEPTH=1024):
- Reset held 0 for 3 edges, then released -> Ready stays 0 for 1024 edges, then rises. A read of Addr=3000 afterwards returns RD=0, RdValid=1.
- Write Addr=2000, WD=32'h11223344, ByteEnable=4'b1100, WPC=32'h3040; then read Addr=2000 -> RD=32'h11220000, WrCount=1, LastWPC=32'h3040.
- Write Addr=2002 (misaligned) with BE=4'b1111 -> AddrErr pulse, WrCount unchanged. Read Addr=4096 (out of range) -> AddrErr=1, RdValid=1, RD=0.
- Write Addr=2000, WD=32'haabbccdd, ByteEnable=0 -> no change. A read returns 32'h11220000 and WrCount stays 1.
- Back-to-back reads of Addr 0, 4, 8 on consecutive edges -> three consecutive RdValid cycles with the correct data.
- Assert Reset=0 at sweep edge 500 -> Ready rises 1024 edges after re-release. The word at Addr=2000 reads 0 afterwards, and WrCount=0.
